// File: rtl/alu_2_if.sv
// Operand/result bundle between the datapath and the alu_2 ALU.
// master drives operands and opcode; slave (the ALU) returns results and flags.
interface alu_2_if #(
   parameter int WIDTH = 64
);
   logic [WIDTH-1:0] rs1;
   logic [WIDTH-1:0] rs2;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] rd;
   logic             zero;
   logic             carry_out;
   logic             overflow;
   logic [WIDTH-1:0] rd_q;
   logic [2:0]       flags_q;

   modport master (
      output rs1, rs2, ALUControl,
      input  rd, zero, carry_out, overflow, rd_q, flags_q
   );

   modport slave (
      input  rs1, rs2, ALUControl,
      output rd, zero, carry_out, overflow, rd_q, flags_q
   );
endinterface

// File: rtl/alu_2.sv
// RV64 integer ALU; ALU2_EXT_OPS_EN adds XOR/shift/set-less-than ops.
// Latency: rd and flags are combinational, rd_q/flags_q follow one clk later.
// Backpressure: none, a new operation is accepted every cycle.
module alu_2 #(
   parameter int WIDTH = 64
) (
   input logic    clk,
   input logic    reset,
   alu_2_if.slave bus
);
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
`ifdef ALU2_EXT_OPS_EN
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam int SHW = $clog2(WIDTH);
`endif

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic             is_sub;
   logic             add_ovf;
   logic [WIDTH-1:0] rd_c;
   logic             carry_c;
   logic             ovf_c;
   logic             zero_c;

   assign a = bus.rs1;
   assign b = bus.rs2;

   // Single adder serves both ADD and SUB: subtraction is a + ~b + 1.
   assign is_sub  = (bus.ALUControl == OP_SUB);
   assign b_op    = is_sub ? ~b : b;
   assign sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
   assign add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU2_EXT_OPS_EN
   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];
`endif

   always_comb begin
      rd_c    = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      case (bus.ALUControl)
         OP_AND: rd_c = a & b;
         OP_OR:  rd_c = a | b;
         OP_ADD, OP_SUB: begin
            rd_c    = sum[WIDTH-1:0];
            carry_c = sum[WIDTH];
            ovf_c   = add_ovf;
         end
`ifdef ALU2_EXT_OPS_EN
         OP_XOR:  rd_c = a ^ b;
         OP_SLL:  rd_c = a << shamt;
         OP_SRL:  rd_c = a >> shamt;
         OP_SRA:  rd_c = $signed(a) >>> shamt;
         OP_SLT:  rd_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: rd_c = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
         default: rd_c = '0;
      endcase
   end

   assign zero_c = (rd_c == '0);

   assign bus.rd        = rd_c;
   assign bus.zero      = zero_c;
   assign bus.carry_out = carry_c;
   assign bus.overflow  = ovf_c;

   // Debug/pipeline copy; reset wins over capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rd_q    <= '0;
         bus.flags_q <= 3'b000;
      end else begin
         bus.rd_q    <= rd_c;
         bus.flags_q <= {ovf_c, carry_c, zero_c};
      end
   end
endmodule

// File: tb/tb_alu_2.sv
// Bench for alu_2: vector table plus chained-add and reset sequences.
module tb_alu_2;
   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;
   localparam logic [3:0] C_XOR = 4'b0011, C_SLL = 4'b0100, C_SRL = 4'b0101, C_SLT = 4'b0111;
   localparam logic [3:0] C_SRA = 4'b1000, C_SLTU = 4'b1001;
`ifdef ALU2_EXT_OPS_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [3:0]  ctrl;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] rd;
      logic [2:0]  fl;   // {overflow, carry_out, zero}
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] rd;
      logic [2:0]  fl;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[$];
   exp_t sb[$];

   alu_2_if #(.WIDTH(64)) bus ();
   alu_2 #(.WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "timeout");
   end

   function automatic vec_t mkv(string n, logic [3:0] c, logic [63:0] a, logic [63:0] b,
                                logic [63:0] rd, logic [2:0] fl);
      vec_t v;
      v.name = n; v.ctrl = c; v.a = a; v.b = b; v.rd = rd; v.fl = fl;
      return v;
   endfunction

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", n, act, exp);
      end
   endtask

   // Drive on the falling edge, check combinational result, then check the registered copy.
   task automatic apply(string n, logic [3:0] c, logic [63:0] a, logic [63:0] b,
                        logic [63:0] exp_rd, logic [2:0] exp_fl);
      exp_t e;
      @(negedge clk);
      bus.ALUControl = c; bus.rs1 = a; bus.rs2 = b;
      #1;
      chk({n, ".rd"}, bus.rd, exp_rd);
      chk({n, ".flags"}, {61'b0, bus.overflow, bus.carry_out, bus.zero}, {61'b0, exp_fl});
      e.name = n;
      e.rd   = reset ? 64'h0 : exp_rd;
      e.fl   = reset ? 3'b000 : exp_fl;
      sb.push_back(e);
      @(posedge clk);
      #1;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s.sb: got empty scoreboard, required one entry", n);
      end else begin
         e = sb.pop_front();
         chk({e.name, ".rd_q"}, bus.rd_q, e.rd);
         chk({e.name, ".flags_q"}, {61'b0, bus.flags_q}, {61'b0, e.fl});
      end
   endtask

   initial begin
      logic [63:0] prev;
      bus.rs1 = '0; bus.rs2 = '0; bus.ALUControl = C_AND;

      vecs.push_back(mkv("add_0_4",   C_ADD, 64'h0, 64'h4, 64'h4, 3'b000));
      vecs.push_back(mkv("add_ovf",   C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 3'b100));
      vecs.push_back(mkv("add_carry", C_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 3'b011));
      vecs.push_back(mkv("sub_eq",    C_SUB, 64'h5, 64'h5, 64'h0, 3'b011));
      vecs.push_back(mkv("sub_borrow",C_SUB, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000));
      vecs.push_back(mkv("sub_ovf",   C_SUB, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110));
      vecs.push_back(mkv("and",       C_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 3'b000));
      vecs.push_back(mkv("or",        C_OR,  64'hF0F0, 64'h0FF0, 64'hFFF0, 3'b000));
      vecs.push_back(mkv("and_zero",  C_AND, 64'hF000, 64'h0F00, 64'h0, 3'b001));
      vecs.push_back(mkv("code_f",    4'b1111, 64'h1234, 64'h5678, 64'h0, 3'b001));
      vecs.push_back(mkv("code_a",    4'b1010, 64'hFFFF, 64'h1, 64'h0, 3'b001));
      vecs.push_back(mkv("xor",  C_XOR, 64'hF0F0, 64'h0FF0,
                         EXT ? 64'hFF00 : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("sra63", C_SRA, 64'h8000_0000_0000_0000, 64'd63,
                         EXT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("sll63", C_SLL, 64'h1, 64'd63,
                         EXT ? 64'h8000_0000_0000_0000 : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("sll0",  C_SLL, 64'hDEAD_BEEF, 64'd0,
                         EXT ? 64'hDEAD_BEEF : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("srl63", C_SRL, 64'h8000_0000_0000_0000, 64'd63,
                         EXT ? 64'h1 : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("srl_lowbits", C_SRL, 64'hF0, 64'h44,
                         EXT ? 64'hF : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("slt", C_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                         EXT ? 64'h1 : 64'h0, EXT ? 3'b000 : 3'b001));
      vecs.push_back(mkv("sltu", C_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 3'b001));

      // Reset state of the registered outputs.
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rd_q", bus.rd_q, 64'h0);
      chk("reset.flags_q", {61'b0, bus.flags_q}, 64'h0);

      // Reset held while an op is applied: combinational path live, registers cleared.
      apply("rst_add", C_ADD, 64'h1, 64'h1, 64'h2, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      apply("rel_add", C_ADD, 64'h1, 64'h1, 64'h2, 3'b000);

      foreach (vecs[i])
         apply(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].fl);

      // PC+4 chain: each step feeds the previous result back as rs1.
      apply("chain0", C_ADD, 64'h0, 64'h4, 64'h4, 3'b000);
      for (int k = 2; k <= 4; k++) begin
         prev = bus.rd_q;
         apply($sformatf("chain%0d", k - 1), C_ADD, prev, 64'h4, 64'(4 * k), 3'b000);
      end

      // Back-to-back ops then reset mid-stream: flags_q clears regardless of prior state.
      apply("b2b_sub", C_SUB, 64'h5, 64'h5, 64'h0, 3'b011);
      @(negedge clk);
      reset = 1'b1;
      apply("rst_mid", C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 3'b100);
      @(negedge clk);
      reset = 1'b0;

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: got %0d leftover entries, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
